// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-first forwarding and a pending-write scoreboard.
// Ports: clk/rst (async active-high); raddr/rdata/rbusy read ports; we/waddr/wdata write ports;
// issue_valid/issue_rd mark a destination pending; flush clears all marks; busy_cnt counts pending;
// dbg_raddr/dbg_rdata read the stored array without forwarding.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int R0_ZERO = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt,
  input  logic [AW-1:0]         dbg_raddr,
  output logic [DATA_W-1:0]     dbg_rdata
);
  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy, busy_nx;
  logic [AW:0]       cnt_nx;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     a;
    logic              hit, zero;
    logic [DATA_W-1:0] fwd;
    assign a    = raddr[i*AW +: AW];
    assign zero = (R0_ZERO != 0) && (a == '0);
    // ascending scan so the highest matching write port is forwarded
    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int j = 0; j < NWR; j++)
        if (we[j] && waddr[j*AW +: AW] == a) begin
          hit = 1'b1;
          fwd = wdata[j*DATA_W +: DATA_W];
        end
    end
    assign rdata[i*DATA_W +: DATA_W] = zero ? '0 : hit ? fwd : mem[a];
    assign rbusy[i] = !zero && !hit && busy[a];
  end
  assign dbg_rdata = ((R0_ZERO != 0) && dbg_raddr == '0) ? '0 : mem[dbg_raddr];
  // write clears first, then issue sets (set wins), flush clears everything last
  always_comb begin
    busy_nx = busy;
    for (int j = 0; j < NWR; j++)
      if (we[j]) busy_nx[waddr[j*AW +: AW]] = 1'b0;
    if (issue_valid) busy_nx[issue_rd] = 1'b1;
    if (flush) busy_nx = '0;
    if (R0_ZERO != 0) busy_nx[0] = 1'b0;
    cnt_nx = '0;
    for (int k = 0; k < NREG; k++) cnt_nx = cnt_nx + (AW+1)'(busy_nx[k]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < NREG; k++) mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && !((R0_ZERO != 0) && waddr[j*AW +: AW] == '0))
          mem[waddr[j*AW +: AW]] <= wdata[j*DATA_W +: DATA_W];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nx;
      busy_cnt <= cnt_nx;
    end
endmodule
